// File: rtl/ram_tester_pkg.sv
// ram_tester_pkg: shared types and helpers for the RAM built-in self-test.
//   state_t : top-level sequencer states
//   ERR_W   : width of the saturating miscompare counter
//   pat()   : test pattern for one word; callers truncate the result to DW
//             (data widths up to 32 bits).
package ram_tester_pkg;

   localparam int ERR_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_t;

   // Address zero-extended and XORed with the seed; inv selects the
   // complemented pattern used by the optional second pass.
   function automatic logic [31:0] pat(input logic [31:0] addr,
                                       input logic [31:0] seed,
                                       input logic        inv);
      logic [31:0] p;
      p = addr ^ seed;
      return inv ? ~p : p;
   endfunction

endpackage

// File: rtl/ram_tester_checker.sv
// ram_tester_checker: read-back compare path.
//   Delays each issued read address and its expected word by two stages to
//   line up with the RAM's read latency, compares against rdata, keeps a
//   saturating miscompare count and captures the first failing address.
// Ports:
//   clk, rst          clock, async active-high reset
//   clr               clears the count, first-error capture and pipeline
//   in_vld/in_last    a read address is being registered this edge / it is
//                     the last one of the pass
//   in_addr, in_exp   that address and its expected data
//   rdata             RAM read data
//   cmp_err           stage-2 slot valid and miscompared (combinational)
//   cmp_last          stage-2 slot holds the last read of the pass
//   err_count, first_err_valid, first_err_addr   results
module ram_tester_checker
   import ram_tester_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_vld,
   input  logic             in_last,
   input  logic [AW-1:0]    in_addr,
   input  logic [DW-1:0]    in_exp,
   input  logic [DW-1:0]    rdata,
   output logic             cmp_err,
   output logic             cmp_last,
   output logic [ERR_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [AW-1:0]    first_err_addr
);

   localparam int STAGES = 2;

   // Stage 1 is loaded on the same edge the address reaches the RAM port;
   // stage 2 on the edge the RAM latches it, so rdata matches stage 2.
   logic [STAGES:1]         vld_pipe;
   logic [STAGES:1]         last_pipe;
   logic [STAGES:1][AW-1:0] addr_pipe;
   logic [STAGES:1][DW-1:0] exp_pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
         addr_pipe <= '0;
         exp_pipe  <= '0;
      end else begin
         vld_pipe  <= clr ? '0 : {vld_pipe[STAGES-1:1], in_vld};
         last_pipe <= clr ? '0 : {last_pipe[STAGES-1:1], in_last};
         addr_pipe <= {addr_pipe[STAGES-1:1], in_addr};
         exp_pipe  <= {exp_pipe[STAGES-1:1], in_exp};
      end
   end

   assign cmp_err  = vld_pipe[STAGES] && (rdata != exp_pipe[STAGES]);
   assign cmp_last = vld_pipe[STAGES] && last_pipe[STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_addr  <= '0;
      end else if (clr) begin
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_addr  <= '0;
      end else if (cmp_err) begin
         if (err_count != '1)
            err_count <= err_count + ERR_W'(1);
         if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= addr_pipe[STAGES];
         end
      end
   end

endmodule

// File: rtl/ram_tester.sv
// ram_tester: BIST initiator for a single-port synchronous RAM.
//   On an accepted start it writes pat(a) to every word, reads every word
//   back and reports miscompares. Owns the RAM port while busy is high.
// Optional build macro:
//   RAM_TESTER_INV_PASS_EN  adds a second write/read pass with ~pat(a);
//                           errors accumulate across both passes.
// Ports:
//   clk, rst                        clock, async active-high reset
//   start, seed                     run request (IDLE/DONE only), pattern seed
//   busy, done, pass                run status; pass valid with done
//   err_count                       saturating miscompare count
//   first_err_valid, first_err_addr first miscompare of the run
//   mem_we, mem_address, mem_wdata  registered RAM port
//   mem_rdata                       RAM read data
module ram_tester
   import ram_tester_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DW-1:0]    seed,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [AW-1:0]    first_err_addr,
   output logic             mem_we,
   output logic [AW-1:0]    mem_address,
   output logic [DW-1:0]    mem_wdata,
   input  logic [DW-1:0]    mem_rdata
);

   localparam logic [AW-1:0] ADDR_MAX = '1;

   state_t        state, state_d;
   logic          we_d, busy_d, done_d, pass_d, rd_d, clr;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] wdata_d, seed_q, seed_d, pat_d;
   logic          inv_nx;
   logic          cmp_err, cmp_last;

`ifdef RAM_TESTER_INV_PASS_EN
   logic inv_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) inv_q <= 1'b0;
      else     inv_q <= inv_nx;
   end
`else
   assign inv_nx = 1'b0;
`endif

   always_comb begin
      state_d = state;
      we_d    = mem_we;
      addr_d  = mem_address;
      busy_d  = busy;
      done_d  = done;
      pass_d  = pass;
      seed_d  = seed_q;
      rd_d    = 1'b0;
      clr     = 1'b0;
`ifdef RAM_TESTER_INV_PASS_EN
      inv_nx  = inv_q;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_d = WRITE;
               clr     = 1'b1;
               seed_d  = seed;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               we_d    = 1'b1;
               addr_d  = '0;
`ifdef RAM_TESTER_INV_PASS_EN
               inv_nx  = 1'b0;
`endif
            end
         end
         WRITE: begin
            if (mem_address == ADDR_MAX) begin
               state_d = READ;
               we_d    = 1'b0;
               addr_d  = '0;
               rd_d    = 1'b1;
            end else begin
               addr_d  = mem_address + AW'(1);
            end
         end
         READ: begin
            // Last address stays on the port through DRAIN.
            if (mem_address == ADDR_MAX) begin
               state_d = DRAIN;
            end else begin
               addr_d  = mem_address + AW'(1);
               rd_d    = 1'b1;
            end
         end
         DRAIN: begin
            if (cmp_last) begin
`ifdef RAM_TESTER_INV_PASS_EN
               if (!inv_q) begin
                  inv_nx  = 1'b1;
                  state_d = WRITE;
                  we_d    = 1'b1;
                  addr_d  = '0;
               end else
`endif
               begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  // The final compare retires on this edge, fold it in.
                  pass_d  = (err_count == '0) && !cmp_err;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // One pattern generator serves both the write data and the expected
      // read data, since a port cycle is either a write or a read.
      pat_d   = DW'(pat(32'(addr_d), 32'(seed_d), inv_nx));
      wdata_d = we_d ? pat_d : mem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         seed_q      <= '0;
      end else begin
         state       <= state_d;
         mem_we      <= we_d;
         mem_address <= addr_d;
         mem_wdata   <= wdata_d;
         busy        <= busy_d;
         done        <= done_d;
         pass        <= pass_d;
         seed_q      <= seed_d;
      end
   end

   ram_tester_checker #(
      .AW (AW),
      .DW (DW)
   ) u_checker (
      .clk             (clk),
      .rst             (rst),
      .clr             (clr),
      .in_vld          (rd_d),
      .in_last         (rd_d && (addr_d == ADDR_MAX)),
      .in_addr         (addr_d),
      .in_exp          (pat_d),
      .rdata           (mem_rdata),
      .cmp_err         (cmp_err),
      .cmp_last        (cmp_last),
      .err_count       (err_count),
      .first_err_valid (first_err_valid),
      .first_err_addr  (first_err_addr)
   );

endmodule

// File: tb/tb_ram_tester.sv
// tb_ram_tester: directed bench for ram_tester with a behavioural RAM that
// can inject read faults. Expected run results are computed from the fault
// model and queued when a run is started, then popped when done rises.
module tb_ram_tester;

   localparam int AW    = 10;
   localparam int DW    = 10;
   localparam int DEPTH = 1 << AW;
`ifdef RAM_TESTER_INV_PASS_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] seed = '0;
   logic          busy, done, pass, first_err_valid, mem_we;
   logic [15:0]   err_count;
   logic [AW-1:0] first_err_addr, mem_address;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   ram_tester #(.AW(AW), .DW(DW)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .seed            (seed),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_count       (err_count),
      .first_err_valid (first_err_valid),
      .first_err_addr  (first_err_addr),
      .mem_we          (mem_we),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata)
   );

   // Fault modes: 0 none, 1 bit 0 reads as 0 at address 7, 2 bit 9 reads as 1.
   int fmode = 0;

   function automatic logic [DW-1:0] ram_fault(input int f, input logic [AW-1:0] a,
                                               input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = d;
      if (f == 1 && a == AW'(7)) r[0] = 1'b0;
      if (f == 2) r[DW-1] = 1'b1;
      return r;
   endfunction

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] ar;

   always @(posedge clk) begin
      if (mem_we) mem[mem_address] <= mem_wdata;
      else        ar <= mem_address;
   end
   assign mem_rdata = ram_fault(fmode, ar, mem[ar]);

   typedef struct {
      logic [15:0]   err;
      logic          fv;
      logic [AW-1:0] fa;
      logic          pass;
      int            lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_model(input logic [DW-1:0] s);
      exp_t          e;
      logic [DW-1:0] w;
      e.err = '0; e.fv = 1'b0; e.fa = '0;
      for (int p = 0; p < NPASS; p++)
         for (int a = 0; a < DEPTH; a++) begin
            w = DW'(a) ^ s;
            if (p == 1) w = ~w;
            if (ram_fault(fmode, AW'(a), w) !== w) begin
               if (e.err != 16'hFFFF) e.err++;
               if (!e.fv) begin e.fv = 1'b1; e.fa = AW'(a); end
            end
         end
      e.pass = (e.err == 0);
      e.lat  = 2049 * NPASS;
      sb.push_back(e);
   endtask

   // Drives start so that the next rising edge is E0, then checks E0 effects.
   task automatic do_start(input logic [DW-1:0] s, input string tag);
      @(negedge clk);
      start = 1'b1;
      seed  = s;
      @(posedge clk);
      #1;
      start = 1'b0;
      seed  = ~s;  // later seed changes must not matter
      check({tag, "_e0_flags"}, 32'({busy, done, pass, first_err_valid, mem_we}), 32'b10001);
      check({tag, "_e0_err"}, 32'(err_count), 0);
      check({tag, "_e0_faddr"}, 32'(first_err_addr), 0);
      check({tag, "_e0_addr"}, 32'(mem_address), 0);
      check({tag, "_e0_wdata"}, 32'(mem_wdata), 32'(s));
   endtask

   task automatic wait_done(input string tag, input int base);
      exp_t e;
      int   k;
      bit   got;
      got = 1'b0;
      k   = base;
      while (!got && k < base + 6000) begin
         @(posedge clk);
         #1;
         k++;
         if (done) got = 1'b1;
      end
      e = sb.pop_front();
      check({tag, "_done"}, 32'(got), 1);
      check({tag, "_latency"}, k, e.lat);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_err"}, 32'(err_count), 32'(e.err));
      check({tag, "_fvalid"}, 32'(first_err_valid), 32'(e.fv));
      check({tag, "_faddr"}, 32'(first_err_addr), 32'(e.fa));
      check({tag, "_pass"}, 32'(pass), 32'(e.pass));
   endtask

   task automatic check_ram(input string tag, input logic [DW-1:0] s);
      int            bad;
      logic [DW-1:0] w;
      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
         w = DW'(a) ^ s;
         if (NPASS == 2) w = ~w;
         if (mem[a] !== w) bad++;
      end
      check(tag, 32'(bad), 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_flags"}, 32'({busy, done, pass, first_err_valid, mem_we}), 0);
      check({tag, "_err"}, 32'(err_count), 0);
      check({tag, "_addrs"}, 32'({first_err_addr, mem_address}), 0);
      check({tag, "_wdata"}, 32'(mem_wdata), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // A: clean RAM, seed 0
      fmode = 0;
      push_model(10'h000);
      do_start(10'h000, "A");
      wait_done("A", 0);
      check_ram("A_ram", 10'h000);

      // B: seed 155, a start with another seed at E100 must be ignored
      push_model(10'h155);
      do_start(10'h155, "B");
      repeat (99) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      seed  = 10'h3FF;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("B_busy_e100", 32'(busy), 1);
      wait_done("B", 100);
      check_ram("B_ram", 10'h155);

      // C: data bit 9 stuck at 1
      fmode = 2;
      push_model(10'h000);
      do_start(10'h000, "C");
      wait_done("C", 0);

      // D: restart from DONE; bit 0 reads 0 at address 7. Seed 0 keeps the
      // stored bit 0 at address 7 high so the stuck-at-0 is observable.
      fmode = 1;
      push_model(10'h000);
      do_start(10'h000, "D");
      wait_done("D", 0);

      // E: reset at E500, outputs cleared, then a full fresh run
      fmode = 0;
      do_start(10'h02A, "E_abort");
      repeat (500) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_zero("E_midrst");
      @(negedge clk);
      rst = 1'b0;
      push_model(10'h02A);
      do_start(10'h02A, "E");
      wait_done("E", 0);
      check_ram("E_ram", 10'h02A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
